// File: rtl/ttm4_sequencer.sv
// TTM4 fetch/execute controller: fetches 8-bit instructions, drives the ALU
// operands and active-low unit enables, and writes the ALU result back.
module ttm4_sequencer #(
    parameter int PC_WIDTH     = 4,
    parameter int RESET_VECTOR = 0
) (
    input  logic                CLK,
    input  logic                RST,
    output logic [PC_WIDTH-1:0] ROM_ADDR,
    input  logic [7:0]          ROM_DATA,
    input  logic [3:0]          IN_PORT,
    output logic [3:0]          ALU_X,
    output logic [3:0]          ALU_Y,
    output logic [1:0]          SEL,
    output logic                nFA_EN,
    output logic                nAND_EN,
    output logic                nOR_EN,
    output logic                nXOR_EN,
    input  logic [3:0]          STOREDATA,
    input  logic                Z_FLAG,
    input  logic                C_FLAG,
    output logic [3:0]          OUT_PORT,
    output logic [3:0]          REG_A,
    output logic [3:0]          REG_B,
    output logic                HALTED
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;
    typedef enum logic [1:0] {D_NONE, D_A, D_B, D_OUT} dst_t;

    // Enable vector order is {FA, AND, OR, XOR}; only one bit may ever be low.
    localparam logic [3:0] EN_IDLE = 4'b1111;
    localparam logic [3:0] EN_FA   = 4'b0111;
    localparam logic [3:0] EN_AND  = 4'b1011;
    localparam logic [3:0] EN_OR   = 4'b1101;
    localparam logic [3:0] EN_XOR  = 4'b1110;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic [3:0]          a_q, a_d, b_q, b_d, out_q, out_d;

    logic [3:0] op, imm, alu_x, alu_y, en_n;
    logic [1:0] sel;
    dst_t       dst;

    // Branches only look at carry; zero is exported by the ALU but not used here.
    logic unused_z;
    assign unused_z = Z_FLAG;

    assign op  = ir_q[7:4];
    assign imm = ir_q[3:0];

    always_comb begin
        alu_x = 4'h0;
        alu_y = 4'h0;
        sel   = 2'b00;
        en_n  = EN_IDLE;
        dst   = D_NONE;
        if (state_q == S_EXEC) begin
            case (op)
                4'h0: begin alu_x = a_q;     alu_y = imm; en_n = EN_FA;  dst = D_A;   end
                4'h1: begin alu_x = b_q;                  en_n = EN_FA;  dst = D_A;   end
                4'h2: begin alu_x = IN_PORT;              en_n = EN_FA;  dst = D_A;   end
                4'h3: begin                  alu_y = imm; en_n = EN_FA;  dst = D_A;   end
                4'h4: begin alu_x = a_q;                  en_n = EN_FA;  dst = D_B;   end
                4'h5: begin alu_x = b_q;     alu_y = imm; en_n = EN_FA;  dst = D_B;   end
                4'h6: begin alu_x = IN_PORT;              en_n = EN_FA;  dst = D_B;   end
                4'h7: begin                  alu_y = imm; en_n = EN_FA;  dst = D_B;   end
                4'h8: begin alu_x = a_q; alu_y = b_q; sel = 2'b01; en_n = EN_AND; dst = D_A; end
                4'h9: begin alu_x = a_q; alu_y = b_q; sel = 2'b10; en_n = EN_OR;  dst = D_A; end
                4'hA: begin alu_x = a_q; alu_y = b_q; sel = 2'b11; en_n = EN_XOR; dst = D_A; end
                4'hB: begin                  alu_y = imm; en_n = EN_FA;  dst = D_OUT; end
                4'hC: begin alu_x = b_q;                  en_n = EN_FA;  dst = D_OUT; end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        case (state_q)
            S_FETCH: begin
                ir_d    = ROM_DATA;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_q + PC_WIDTH'(1);
                case (dst)
                    D_A:     a_d   = STOREDATA;
                    D_B:     b_d   = STOREDATA;
                    D_OUT:   out_d = STOREDATA;
                    default: ;
                endcase
                if (op == 4'hD) begin
                    state_d = S_HALT;
                    pc_d    = pc_q;
                end else if ((op == 4'hE && !C_FLAG) || op == 4'hF) begin
                    pc_d = PC_WIDTH'(imm);
                end
            end
            S_HALT:  ;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_FETCH;
            pc_q    <= PC_WIDTH'(RESET_VECTOR);
            ir_q    <= 8'h00;
            a_q     <= 4'h0;
            b_q     <= 4'h0;
            out_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
        end
    end

    assign ROM_ADDR = pc_q;
    assign ALU_X    = alu_x;
    assign ALU_Y    = alu_y;
    assign SEL      = sel;
    assign {nFA_EN, nAND_EN, nOR_EN, nXOR_EN} = en_n;
    assign OUT_PORT = out_q;
    assign REG_A    = a_q;
    assign REG_B    = b_q;
    assign HALTED   = (state_q == S_HALT);

endmodule
